apb_master_ctrl: RTL

//  Parametrised APB master: accepts single read/write requests on a valid/ready

---
 rtl/apb_master_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/apb_master_ctrl.sv
// APB master controller: takes single read/write requests on a valid/ready port
// and runs them as IDLE->SETUP->ACCESS transfers on a multi-slave APB segment.
module apb_master_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [NUM_SLAVES-1:0]        psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDR_W-1:0]            paddr,
  output logic [DATA_W-1:0]            pwdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES-1:0]        pslverr
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  dec_ok_s;
  logic                  sel_ready_s;
  logic                  sel_err_s;
  logic [DATA_W-1:0]     sel_rdata_s;
  logic                  timeout_s;
  logic                  done_s;
  logic                  accept_s;

  // AND-OR mux of the latched slave's response; an out-of-range index selects nothing
  always_comb begin
    dec_ok_s    = 1'b0;
    sel_ready_s = 1'b0;
    sel_err_s   = 1'b0;
    sel_rdata_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec_ok_s    = dec_ok_s    | (idx_q == SEL_W'(i));
      sel_ready_s = sel_ready_s | (pready[i]  & (idx_q == SEL_W'(i)));
      sel_err_s   = sel_err_s   | (pslverr[i] & (idx_q == SEL_W'(i)));
      sel_rdata_s = sel_rdata_s | (prdata[i*DATA_W +: DATA_W] & {DATA_W{idx_q == SEL_W'(i)}});
    end
  end

  // Completion of the ACCESS phase and the combinational handshake
  always_comb begin
    timeout_s = (TIMEOUT != 0) && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    done_s    = (state_q == S_ACCESS) && (!dec_ok_s || sel_ready_s || timeout_s);
    req_ready = (state_q == S_IDLE) || done_s;
    accept_s  = req_valid && req_ready;
  end

  // Next state, request latching, response generation and APB output decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d    = S_ACCESS;
        wait_cnt_d = '0;
      end
      S_ACCESS: begin
        if (done_s) begin
          rsp_valid_d = 1'b1;
          // pready wins over a coincident timeout
          rsp_err_d   = !dec_ok_s || !sel_ready_s || sel_err_s;
          rsp_rdata_d = (!pwrite_q && dec_ok_s && sel_ready_s && !sel_err_s) ? sel_rdata_s : '0;
          wait_cnt_d  = '0;
          state_d     = accept_s ? S_SETUP : S_IDLE;
        end else begin
          wait_cnt_d  = wait_cnt_q + CNT_W'(1);
          state_d     = S_ACCESS;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept_s) begin
      idx_d    = req_addr[ADDR_W-1 -: SEL_W];
      paddr_d  = req_addr;
      pwdata_d = req_wdata;
      pwrite_d = req_write;
    end else begin
      idx_d    = idx_q;
    end

    // Outputs are registered, so they are decoded from the state being entered
    for (int i = 0; i < NUM_SLAVES; i++) begin
      psel_d[i] = (state_d != S_IDLE) && (idx_d == SEL_W'(i));
    end
    penable_d = (state_d == S_ACCESS) && (|psel_d);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wait_cnt_q  <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_cnt_q  <= wait_cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
